// File: rtl/aq_mmu_sysmap_cfg_if.sv
// Bus bundle for the sysmap configuration block.
// Carries the CSR write port, the readback port and the lookup request/response.
interface aq_mmu_sysmap_cfg_if #(
  parameter int ENTRY_NUM = 8,
  parameter int ADDR_W    = 28,
  parameter int ATTR_W    = 5,
  parameter int IDX_W     = 3
);
  logic                 cfg_wr_vld;
  logic                 cfg_wr_rdy;
  logic                 cfg_wr_sel;
  logic [IDX_W-1:0]     cfg_wr_idx;
  logic [ADDR_W-1:0]    cfg_wr_data;
  logic [IDX_W-1:0]     cfg_rd_idx;
  logic [ADDR_W-1:0]    cfg_rd_upaddr;
  logic [ATTR_W-1:0]    cfg_rd_attr;
  logic                 cfg_upd_pulse;
  logic                 lkup_vld;
  logic [ADDR_W-1:0]    lkup_ppn;
  logic                 lkup_stall;
  logic                 rsp_vld;
  logic [ENTRY_NUM-1:0] addr_ge_bottom;
  logic [ENTRY_NUM-1:0] sysmap_comp_hit;
  logic                 rsp_hit;
  logic [ATTR_W-1:0]    rsp_attr;

  modport master (
    output cfg_wr_vld, cfg_wr_sel, cfg_wr_idx, cfg_wr_data, cfg_rd_idx,
           lkup_vld, lkup_ppn,
    input  cfg_wr_rdy, cfg_rd_upaddr, cfg_rd_attr, cfg_upd_pulse,
           lkup_stall, rsp_vld, addr_ge_bottom, sysmap_comp_hit, rsp_hit, rsp_attr
  );

  modport slave (
    input  cfg_wr_vld, cfg_wr_sel, cfg_wr_idx, cfg_wr_data, cfg_rd_idx,
           lkup_vld, lkup_ppn,
    output cfg_wr_rdy, cfg_rd_upaddr, cfg_rd_attr, cfg_upd_pulse,
           lkup_stall, rsp_vld, addr_ge_bottom, sysmap_comp_hit, rsp_hit, rsp_attr
  );
endinterface

// File: rtl/aq_mmu_sysmap_cfg.sv
// Sysmap address-attribute map: programmable region table plus lookup driver.
// Writes take an IDLE->COMMIT round trip; lookups are blocked only while committing,
// so a response always sees a stable table.
module aq_mmu_sysmap_cfg #(
  parameter int                ENTRY_NUM = 8,
  parameter int                ADDR_W    = 28,
  parameter int                ATTR_W    = 5,
  parameter int                IDX_W     = 3,
  parameter logic [ATTR_W-1:0] DFLT_ATTR = ATTR_W'(5'b01111)
) (
  input logic                 forever_cpuclk,
  input logic                 cpurst_b,
  aq_mmu_sysmap_cfg_if.slave  bus
);

  typedef enum logic {IDLE, COMMIT} state_t;

  state_t state;
  state_t state_nxt;

  logic              wr_rdy;
  logic              stall;
  logic              upd_pulse;
  logic              wr_sel_q;
  logic [IDX_W-1:0]  wr_idx_q;
  logic [ADDR_W-1:0] wr_data_q;

  logic [ADDR_W-1:0] upaddr [ENTRY_NUM];
  logic [ATTR_W-1:0] attr   [ENTRY_NUM];
  logic [ADDR_W-1:0] bottom [ENTRY_NUM];

  logic                 accept;
  logic [ENTRY_NUM-1:0] ge_nxt;
  logic [ENTRY_NUM-1:0] comp_nxt;
  logic                 hit_nxt;
  logic [ATTR_W-1:0]    attr_nxt;

  logic                 rsp_vld_q;
  logic [ENTRY_NUM-1:0] ge_q;
  logic [ENTRY_NUM-1:0] comp_q;
  logic                 hit_q;
  logic [ATTR_W-1:0]    attr_q;

  // Write FSM state register.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) state <= IDLE;
    else           state <= state_nxt;
  end

  // Write FSM next state and handshake outputs; COMMIT is the single update cycle.
  always_comb begin
    state_nxt = state;
    wr_rdy    = 1'b0;
    stall     = 1'b0;
    upd_pulse = 1'b0;
    case (state)
      IDLE: begin
        wr_rdy = 1'b1;
        if (bus.cfg_wr_vld) state_nxt = COMMIT;
      end
      COMMIT: begin
        stall     = 1'b1;
        upd_pulse = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the write request when it is accepted in IDLE.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      wr_sel_q  <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else if (state == IDLE && bus.cfg_wr_vld) begin
      wr_sel_q  <= bus.cfg_wr_sel;
      wr_idx_q  <= bus.cfg_wr_idx;
      wr_data_q <= bus.cfg_wr_data;
    end
  end

  // Region table; the last entry resets to cover the whole space with the default attribute.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (i == ENTRY_NUM - 1) begin
          upaddr[i] <= '1;
          attr[i]   <= DFLT_ATTR;
        end else begin
          upaddr[i] <= '0;
          attr[i]   <= '0;
        end
      end
    end else if (state == COMMIT) begin
      if (wr_sel_q) attr[wr_idx_q]   <= wr_data_q[ATTR_W-1:0];
      else          upaddr[wr_idx_q] <= wr_data_q;
    end
  end

  // Per-entry range compare against the current table; lowest-index hit wins.
  always_comb begin
    ge_nxt   = '0;
    comp_nxt = '0;
    hit_nxt  = 1'b0;
    attr_nxt = '0;
    bottom[0] = '0;
    for (int i = 1; i < ENTRY_NUM; i++) bottom[i] = upaddr[i-1];
    for (int i = 0; i < ENTRY_NUM; i++) begin
      ge_nxt[i]   = (bus.lkup_ppn >= bottom[i]);
      comp_nxt[i] = (bus.lkup_ppn < upaddr[i]);
      if (!hit_nxt && ge_nxt[i] && comp_nxt[i]) begin
        hit_nxt  = 1'b1;
        attr_nxt = attr[i];
      end
    end
  end

  assign accept = bus.lkup_vld & ~stall;

  // Response registers: loaded on accept, otherwise held; rsp_vld pulses once per accept.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rsp_vld_q <= 1'b0;
      ge_q      <= '0;
      comp_q    <= '0;
      hit_q     <= 1'b0;
      attr_q    <= '0;
    end else begin
      rsp_vld_q <= accept;
      if (accept) begin
        ge_q   <= ge_nxt;
        comp_q <= comp_nxt;
        hit_q  <= hit_nxt;
        attr_q <= attr_nxt;
      end
    end
  end

  assign bus.cfg_wr_rdy      = wr_rdy;
  assign bus.cfg_upd_pulse   = upd_pulse;
  assign bus.lkup_stall      = stall;
  assign bus.cfg_rd_upaddr   = upaddr[bus.cfg_rd_idx];
  assign bus.cfg_rd_attr     = attr[bus.cfg_rd_idx];
  assign bus.rsp_vld         = rsp_vld_q;
  assign bus.addr_ge_bottom  = ge_q;
  assign bus.sysmap_comp_hit = comp_q;
  assign bus.rsp_hit         = hit_q;
  assign bus.rsp_attr        = attr_q;

endmodule

// File: tb/tb_aq_mmu_sysmap_cfg.sv
// Bench for aq_mmu_sysmap_cfg: directed scenarios then random traffic, checked by a
// scoreboard fed from a region-table reference model.
module tb_aq_mmu_sysmap_cfg;
  localparam int ENTRY_NUM = 8;
  localparam int ADDR_W    = 28;
  localparam int ATTR_W    = 5;
  localparam int IDX_W     = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  aq_mmu_sysmap_cfg_if #(.ENTRY_NUM(ENTRY_NUM), .ADDR_W(ADDR_W), .ATTR_W(ATTR_W), .IDX_W(IDX_W)) bus_if ();

  aq_mmu_sysmap_cfg #(.ENTRY_NUM(ENTRY_NUM), .ADDR_W(ADDR_W), .ATTR_W(ATTR_W), .IDX_W(IDX_W)) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .bus            (bus_if)
  );

  typedef struct packed {
    logic [ENTRY_NUM-1:0] ge;
    logic [ENTRY_NUM-1:0] comp;
    logic                 hit;
    logic [ATTR_W-1:0]    attr;
  } exp_t;

  int compared   = 0;
  int mismatched = 0;

  exp_t exp_q[$];
  exp_t last_exp;

  logic [ADDR_W-1:0] up_m   [ENTRY_NUM];
  logic [ATTR_W-1:0] attr_m [ENTRY_NUM];
  bit                pend_m;
  bit                sel_m;
  logic [IDX_W-1:0]  idx_m;
  logic [ADDR_W-1:0] data_m;

  // Table and write-pending state as they stand after reset.
  function automatic void reset_model();
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (i == ENTRY_NUM - 1) begin
        up_m[i]   = '1;
        attr_m[i] = 5'b01111;
      end else begin
        up_m[i]   = '0;
        attr_m[i] = '0;
      end
    end
    pend_m   = 1'b0;
    sel_m    = 1'b0;
    idx_m    = '0;
    data_m   = '0;
    last_exp = '0;
    exp_q.delete();
  endfunction

  // Region i spans [up[i-1], up[i]) with region 0 starting at 0; first matching region wins.
  function automatic exp_t predict(input logic [ADDR_W-1:0] ppn);
    exp_t e;
    logic [ADDR_W-1:0] lo;
    e = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (i > 0) lo = up_m[i-1];
      else       lo = '0;
      e.ge[i]   = (ppn >= lo);
      e.comp[i] = (ppn < up_m[i]);
      if (!e.hit && ppn >= lo && ppn < up_m[i]) begin
        e.hit  = 1'b1;
        e.attr = attr_m[i];
      end
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, required, $time);
    end
  endtask

  // One cycle of input drive, applied just after the rising edge.
  task automatic applyStimulus(input bit wv, input bit sel, input logic [IDX_W-1:0] idx,
                               input logic [ADDR_W-1:0] data, input bit lv,
                               input logic [ADDR_W-1:0] ppn, input logic [IDX_W-1:0] rdi);
    @(posedge clk);
    #1;
    bus_if.cfg_wr_vld  = wv;
    bus_if.cfg_wr_sel  = sel;
    bus_if.cfg_wr_idx  = idx;
    bus_if.cfg_wr_data = data;
    bus_if.lkup_vld    = lv;
    bus_if.lkup_ppn    = ppn;
    bus_if.cfg_rd_idx  = rdi;
  endtask

  // Reference model: a write is taken when idle and lands one edge later; lookups are
  // taken whenever no write is landing and see the table before this edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reset_model();
    end else begin
      if (bus_if.lkup_vld && !pend_m) exp_q.push_back(predict(bus_if.lkup_ppn));
      if (pend_m) begin
        if (sel_m) attr_m[idx_m] = data_m[ATTR_W-1:0];
        else       up_m[idx_m]   = data_m;
        pend_m = 1'b0;
      end else if (bus_if.cfg_wr_vld) begin
        sel_m  = bus_if.cfg_wr_sel;
        idx_m  = bus_if.cfg_wr_idx;
        data_m = bus_if.cfg_wr_data;
        pend_m = 1'b1;
      end
    end
  end

  // Monitor on the falling edge: handshake, readback and scoreboard responses.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_rsp_vld",   32'(bus_if.rsp_vld),       32'd0);
      checkOutput("rst_upd_pulse", 32'(bus_if.cfg_upd_pulse), 32'd0);
      checkOutput("rst_wr_rdy",    32'(bus_if.cfg_wr_rdy),    32'd1);
    end else begin
      checkOutput("wr_rdy",     32'(bus_if.cfg_wr_rdy),    32'(!pend_m));
      checkOutput("lkup_stall", 32'(bus_if.lkup_stall),    32'(pend_m));
      checkOutput("upd_pulse",  32'(bus_if.cfg_upd_pulse), 32'(pend_m));
      checkOutput("rd_upaddr",  32'(bus_if.cfg_rd_upaddr), 32'(up_m[bus_if.cfg_rd_idx]));
      checkOutput("rd_attr",    32'(bus_if.cfg_rd_attr),   32'(attr_m[bus_if.cfg_rd_idx]));
      if (bus_if.rsp_vld) begin
        if (exp_q.size() == 0) begin
          checkOutput("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          last_exp = exp_q.pop_front();
        end
      end else if (exp_q.size() != 0) begin
        checkOutput("rsp_missing", 32'd0, 32'd1);
        last_exp = exp_q.pop_front();
      end
      checkOutput("addr_ge_bottom",  32'(bus_if.addr_ge_bottom),  32'(last_exp.ge));
      checkOutput("sysmap_comp_hit", 32'(bus_if.sysmap_comp_hit), 32'(last_exp.comp));
      checkOutput("rsp_hit",         32'(bus_if.rsp_hit),         32'(last_exp.hit));
      checkOutput("rsp_attr",        32'(bus_if.rsp_attr),        32'(last_exp.attr));
    end
  end

  logic [ADDR_W-1:0] ppn_r;
  int                k;

  initial begin
    bus_if.cfg_wr_vld  = 1'b0;
    bus_if.cfg_wr_sel  = 1'b0;
    bus_if.cfg_wr_idx  = '0;
    bus_if.cfg_wr_data = '0;
    bus_if.lkup_vld    = 1'b0;
    bus_if.lkup_ppn    = '0;
    bus_if.cfg_rd_idx  = '0;
    reset_model();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset table: only the last entry covers the lookup.
    applyStimulus(0, 0, 0, '0, 1, 28'h1234567, 7);
    applyStimulus(0, 0, 0, '0, 0, '0, 7);
    // Program entry 0 upper address and attribute.
    applyStimulus(1, 0, 0, 28'h0080000, 0, '0, 0);
    applyStimulus(0, 0, 0, '0, 0, '0, 0);
    applyStimulus(1, 1, 0, 28'hFFFFFF3, 0, '0, 0);
    applyStimulus(0, 0, 0, '0, 0, '0, 0);
    // Boundary lookups around entry 0's upper address.
    applyStimulus(0, 0, 0, '0, 1, 28'h007FFFF, 0);
    applyStimulus(0, 0, 0, '0, 1, 28'h0080000, 0);
    // Write and lookup in the same cycle, then the lookup held through the commit.
    applyStimulus(1, 0, 3, 28'h0100000, 1, 28'h0090000, 3);
    applyStimulus(0, 0, 0, '0, 1, 28'h0090000, 3);
    applyStimulus(0, 0, 0, '0, 1, 28'h0090000, 3);
    applyStimulus(0, 0, 0, '0, 0, '0, 3);
    // Shrink the last region so the top of the space maps nowhere.
    applyStimulus(1, 0, 7, 28'h0100000, 0, '0, 7);
    applyStimulus(0, 0, 0, '0, 0, '0, 7);
    applyStimulus(0, 0, 0, '0, 1, 28'h0FFFFFF, 7);
    applyStimulus(0, 0, 0, '0, 0, '0, 7);

    // Reset in the middle of a commit with a response in flight.
    applyStimulus(1, 1, 7, 28'h0000005, 1, 28'h0FFFFFF, 7);
    @(posedge clk);
    #1;
    bus_if.cfg_wr_vld = 1'b0;
    bus_if.lkup_vld   = 1'b0;
    #1 rst_n = 1'b0;
    #6 rst_n = 1'b1;
    applyStimulus(0, 0, 0, '0, 1, 28'h1234567, 7);
    applyStimulus(0, 0, 0, '0, 1, 28'h0FFFFFF, 0);
    applyStimulus(0, 0, 0, '0, 0, '0, 0);

    // Random traffic, with lookups biased toward region boundaries.
    for (int n = 0; n < 400; n++) begin
      k = int'($urandom_range(ENTRY_NUM - 1));
      case ($urandom_range(3))
        0:       ppn_r = up_m[k] - 28'd1;
        1:       ppn_r = up_m[k];
        2:       ppn_r = up_m[k] + 28'd1;
        default: ppn_r = ADDR_W'($urandom);
      endcase
      applyStimulus(($urandom_range(3) == 0), 1'($urandom), IDX_W'($urandom),
                    ($urandom_range(1) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(32'h000FFFF)),
                    1'($urandom), ppn_r, IDX_W'($urandom));
    end
    applyStimulus(0, 0, 0, '0, 0, '0, 0);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/aq_mmu_sysmap_cfg.md
Name: aq_mmu_sysmap_cfg

Overview:
- Programming and lookup-driver side of the sysmap address-attribute map.
- Holds ENTRY_NUM region upper-address and attribute registers, written through a CSR-side valid/ready port.
- Compares a registered lookup physical page number against every entry and drives the per-entry comparison pair consumed by the per-entry sysmap hit cells: addr_ge_bottom_x and sysmap_comp_hit_x.
- Also returns the resolved attribute of the winning entry one cycle after the lookup.

Parameters:
- ENTRY_NUM, 8, number of sysmap regions (power of 2, 2..16).
- ADDR_W, 28, page-number width (PA[39:12]).
- ATTR_W, 5, attribute width.
- IDX_W, 3, log2(ENTRY_NUM).
- DFLT_ATTR, 5'b01111, reset attribute of the last entry.

Ports:
- forever_cpuclk  in  1  clock.
- cpurst_b  in  1  reset, asynchronous, active-low.
- cfg_wr_vld  in  1  write request.
- cfg_wr_rdy  out  1  write accept.
- cfg_wr_sel  in  1  0 = upper address, 1 = attribute.
- cfg_wr_idx  in  IDX_W  target entry.
- cfg_wr_data  in  ADDR_W  write data; attribute uses [ATTR_W-1:0].
- cfg_rd_idx  in  IDX_W  readback index.
- cfg_rd_upaddr  out  ADDR_W  combinational readback of the selected entry's upper address.
- cfg_rd_attr  out  ATTR_W  combinational readback of the selected entry's attribute.
- cfg_upd_pulse  out  1  one-cycle pulse on commit; used for downstream TLB/uTLB attribute flush.
- lkup_vld  in  1  lookup request.
- lkup_ppn  in  ADDR_W  lookup page number.
- lkup_stall  out  1  lookup not accepted this cycle.
- rsp_vld  out  1  lookup response valid.
- addr_ge_bottom  out  ENTRY_NUM  per-entry ppn >= bottom.
- sysmap_comp_hit  out  ENTRY_NUM  per-entry ppn < upaddr.
- rsp_hit  out  1  some entry hit.
- rsp_attr  out  ATTR_W  attribute of the hit entry.

Behaviour:
Reset:
- upaddr[i] = 0 for i < ENTRY_NUM-1; upaddr[ENTRY_NUM-1] = all ones.
- attr[i] = 0 for i < ENTRY_NUM-1; attr[ENTRY_NUM-1] = DFLT_ATTR.
- cfg_wr_rdy = 1.
- rsp_vld, cfg_upd_pulse, addr_ge_bottom, sysmap_comp_hit, rsp_hit, rsp_attr all 0.

Write FSM, states IDLE and COMMIT:
- IDLE, cfg_wr_vld = 1: capture sel/idx/data; go to COMMIT. cfg_wr_rdy = 1 in IDLE.
- COMMIT: update the target register, pulse cfg_upd_pulse, drive cfg_wr_rdy = 0 and lkup_stall = 1, return to IDLE.
- Back-to-back writes therefore take 2 cycles each.
- Out-of-range idx (ENTRY_NUM not a power of 2 is illegal) does not occur.
- Attribute writes ignore cfg_wr_data[ADDR_W-1:ATTR_W].

Lookup pipeline:
- Accepted when lkup_vld = 1 and lkup_stall = 0.
- Next cycle, rsp_vld = 1 and the outputs reflect the table contents as they stood at the accept edge.
- A write committing in the same cycle as a response does not alter that response.
- lkup_stall = 1 only in COMMIT. A lookup presented then is not accepted and the requester holds it. No response is generated.
- Per entry i:
  - bottom(0) = 0; bottom(i) = upaddr[i-1].
  - addr_ge_bottom[i] = (ppn >= bottom(i)), unsigned.
  - sysmap_comp_hit[i] = (ppn < upaddr[i]), unsigned.
- Hit and attribute:
  - hit_i = addr_ge_bottom[i] & sysmap_comp_hit[i].
  - rsp_hit = OR of hit_i.
  - rsp_attr = attr of the lowest-index hit entry; 0 if none.
- Non-monotonic tables (upaddr[i] < upaddr[i-1]) make entry i empty. No error is flagged.
- Outputs are held when no response is issued; rsp_vld is a single-cycle pulse per accepted lookup.

Reset mid-operation:
- Pending COMMIT is discarded; the table returns to reset values.
- An in-flight response is dropped (rsp_vld = 0).

Test Plan:
- Reset, lookup ppn = 0x1234567 -> next cycle rsp_vld = 1, hit only on entry 7, rsp_attr = 5'b01111, addr_ge_bottom = 8'hFF, sysmap_comp_hit = 8'h80.
- Write upaddr[0] = 0x0080000 -> cfg_wr_rdy low for exactly 1 cycle; cfg_upd_pulse once; readback idx 0 returns 0x0080000.
- With upaddr[0] = 0x0080000 and attr[0] = 5'b10011, lookup ppn = 0x007FFFF -> rsp_hit = 1, attr 5'b10011.
- Same table, lookup ppn = 0x0080000 -> entry 0 misses (boundary exclusive), rsp_hit = 1, attr 5'b01111.
- Lookup presented during COMMIT -> lkup_stall = 1 and no rsp_vld that cycle. Lookup accepted in the cycle the write is accepted -> response uses the old table.
- Set upaddr[7] = 0x0100000, lookup ppn = 0x0FFFFFF -> rsp_hit = 0, rsp_attr = 0.
- Assert cpurst_b low during COMMIT -> table returns to reset values; cfg_upd_pulse and rsp_vld = 0.
